// File: rtl/execute_stage_pkg.sv
// Shared RV32I encoding constants plus the EX/MEM pipeline register image.
// Used by the decode, execute and memory stages.
//   - opcode constants (LUI..SYS), NOP encoding, funct3 codes
//   - op_class_e / decode_op: opcode -> instruction class (unknown -> bubble)
//   - ex_mem_t / EX_MEM_BUBBLE: EX/MEM register contents and the bubble image
//   - store_lanes: byte/halfword replication of store data
package execute_stage_pkg;

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BCC   = 7'b1100011;
  localparam logic [6:0] OPC_LCC   = 7'b0000011;
  localparam logic [6:0] OPC_SCC   = 7'b0100011;
  localparam logic [6:0] OPC_MCC   = 7'b0010011;
  localparam logic [6:0] OPC_RCC   = 7'b0110011;
  localparam logic [6:0] OPC_SYS   = 7'b1110011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // ALU funct3
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  // branch funct3
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  // store funct3
  localparam logic [2:0] F3_SB   = 3'd0;
  localparam logic [2:0] F3_SH   = 3'd1;
  localparam logic [2:0] F3_SW   = 3'd2;

  typedef enum logic [3:0] {
    CLS_BUBBLE, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR,
    CLS_BCC, CLS_LCC, CLS_SCC, CLS_MCC, CLS_RCC, CLS_SYS
  } op_class_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [31:0] csr_data;
    logic [4:0]  rd;
    logic        is_load;
    logic        is_store;
    logic        is_sys;
  } ex_mem_t;

  localparam ex_mem_t EX_MEM_BUBBLE = '{
    pc: 32'h0, inst: NOP_INST, alu: 32'h0, rs2: 32'h0, csr_data: 32'h0,
    rd: 5'h0, is_load: 1'b0, is_store: 1'b0, is_sys: 1'b0
  };

  function automatic op_class_e decode_op(input logic [6:0] opc);
    case (opc)
      OPC_LUI:   return CLS_LUI;
      OPC_AUIPC: return CLS_AUIPC;
      OPC_JAL:   return CLS_JAL;
      OPC_JALR:  return CLS_JALR;
      OPC_BCC:   return CLS_BCC;
      OPC_LCC:   return CLS_LCC;
      OPC_SCC:   return CLS_SCC;
      OPC_MCC:   return CLS_MCC;
      OPC_RCC:   return CLS_RCC;
      OPC_SYS:   return CLS_SYS;
      default:   return CLS_BUBBLE;
    endcase
  endfunction

  // Replicate narrow store data across all byte lanes so the memory stage
  // only has to drive byte enables.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3,
                                              input logic [31:0] data);
    case (f3)
      F3_SB:   return {4{data[7:0]}};
      F3_SH:   return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Purely combinational RV32I ALU.
//   a, b    : operands
//   funct3  : operation select
//   alt     : SUB instead of ADD, SRA instead of SRL
//   result  : 32-bit result
module alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic        alt,
  output logic [31:0] result
);

  always_comb begin
    result = 32'h0;
    case (funct3)
      F3_ADD:  result = alt ? (a - b) : (a + b);
      F3_SLL:  result = a << b[4:0];
      F3_SLT:  result = {31'h0, $signed(a) < $signed(b)};
      F3_SLTU: result = {31'h0, a < b};
      F3_XOR:  result = a ^ b;
      F3_SR:   result = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      F3_OR:   result = a | b;
      F3_AND:  result = a & b;
      default: result = 32'h0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, branch/jump resolution and the EX/MEM register.
//   CLK, RST            : clock, asynchronous active-high reset
//   HREADY_D            : data-bus ready; low stalls EX/MEM (ex_stall = ~HREADY_D)
//   ID_EX_*             : decoded instruction and forwarded operands
//   EX_MEM_*            : registered results for the memory stage
//   branch_taken/target : combinational fetch redirect
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        HREADY_D,
  input  logic        ID_EX_valid,
  input  logic [31:0] ID_EX_pc,
  input  logic [31:0] ID_EX_inst,
  input  logic [31:0] ID_EX_rs1,
  input  logic [31:0] ID_EX_rs2,
  input  logic [31:0] ID_EX_imm,
  input  logic [4:0]  ID_EX_rd,
  input  logic [31:0] ID_EX_csr_rdata,
  output logic [31:0] EX_MEM_pc,
  output logic [31:0] EX_MEM_inst,
  output logic [31:0] EX_MEM_alu,
  output logic [31:0] EX_MEM_rs2,
  output logic [31:0] EX_MEM_csr_data,
  output logic [4:0]  EX_MEM_rd,
  output logic        EX_MEM_is_load,
  output logic        EX_MEM_is_store,
  output logic        EX_MEM_is_sys,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        ex_stall
);

  op_class_e   cls;
  logic [2:0]  funct3;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_f3;
  logic        alu_alt;
  logic        br_cond;
  logic        take;
  ex_mem_t     ex_mem_d, ex_mem_q;

  assign funct3 = ID_EX_inst[14:12];
  assign cls    = ID_EX_valid ? decode_op(ID_EX_inst[6:0]) : CLS_BUBBLE;

  // Non-arithmetic classes reuse the adder with funct3=ADD.
  always_comb begin
    alu_a   = ID_EX_rs1;
    alu_b   = ID_EX_imm;
    alu_f3  = F3_ADD;
    alu_alt = 1'b0;
    case (cls)
      CLS_LUI:   alu_a = 32'h0;
      CLS_AUIPC: alu_a = ID_EX_pc;
      CLS_JAL, CLS_JALR: begin
        alu_a = ID_EX_pc;
        alu_b = 32'd4;
      end
      CLS_MCC: begin
        alu_f3  = funct3;
        // inst[30] is part of the immediate for ADDI, so only SRAI honours it
        alu_alt = (funct3 == F3_SR) & ID_EX_inst[30];
      end
      CLS_RCC: begin
        alu_b   = ID_EX_rs2;
        alu_f3  = funct3;
        alu_alt = ((funct3 == F3_ADD) | (funct3 == F3_SR)) & ID_EX_inst[30];
      end
      default: ;
    endcase
  end

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .funct3 (alu_f3),
    .alt    (alu_alt),
    .result (alu_result)
  );

  always_comb begin
    br_cond = 1'b0;
    case (funct3)
      F3_BEQ:  br_cond = (ID_EX_rs1 == ID_EX_rs2);
      F3_BNE:  br_cond = (ID_EX_rs1 != ID_EX_rs2);
      F3_BLT:  br_cond = ($signed(ID_EX_rs1) <  $signed(ID_EX_rs2));
      F3_BGE:  br_cond = ($signed(ID_EX_rs1) >= $signed(ID_EX_rs2));
      F3_BLTU: br_cond = (ID_EX_rs1 <  ID_EX_rs2);
      F3_BGEU: br_cond = (ID_EX_rs1 >= ID_EX_rs2);
      default: br_cond = 1'b0;
    endcase
  end

  assign take = (cls == CLS_JAL) | (cls == CLS_JALR) | ((cls == CLS_BCC) & br_cond);
  // A stalled instruction must not redirect yet; it redirects on the cycle
  // it is actually accepted, so the redirect happens exactly once.
  assign branch_taken  = take & HREADY_D & ~RST;
  assign branch_target = (cls == CLS_JALR) ? ((ID_EX_rs1 + ID_EX_imm) & ~32'd1)
                                           : (ID_EX_pc + ID_EX_imm);
  assign ex_stall      = ~HREADY_D;

  always_comb begin
    ex_mem_d = ex_mem_q;
    if (HREADY_D) begin
      ex_mem_d    = EX_MEM_BUBBLE;
      ex_mem_d.pc = ex_mem_q.pc;   // bubbles keep the last pc
      if (cls != CLS_BUBBLE) begin
        ex_mem_d.pc   = ID_EX_pc;
        ex_mem_d.inst = ID_EX_inst;
        ex_mem_d.alu  = alu_result;
        ex_mem_d.rs2  = ID_EX_rs2;
        ex_mem_d.rd   = ID_EX_rd;
        case (cls)
          CLS_BCC: begin
            ex_mem_d.alu = 32'h0;
            ex_mem_d.rd  = 5'h0;
          end
          CLS_SCC: begin
            ex_mem_d.rd       = 5'h0;
            ex_mem_d.rs2      = store_lanes(funct3, ID_EX_rs2);
            ex_mem_d.is_store = 1'b1;
          end
          CLS_LCC: ex_mem_d.is_load = 1'b1;
          CLS_SYS: begin
            ex_mem_d.alu      = 32'h0;
            ex_mem_d.csr_data = ID_EX_csr_rdata;
            ex_mem_d.is_sys   = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ex_mem_q <= EX_MEM_BUBBLE;
    else     ex_mem_q <= ex_mem_d;
  end

  assign EX_MEM_pc       = ex_mem_q.pc;
  assign EX_MEM_inst     = ex_mem_q.inst;
  assign EX_MEM_alu      = ex_mem_q.alu;
  assign EX_MEM_rs2      = ex_mem_q.rs2;
  assign EX_MEM_csr_data = ex_mem_q.csr_data;
  assign EX_MEM_rd       = ex_mem_q.rd;
  assign EX_MEM_is_load  = ex_mem_q.is_load;
  assign EX_MEM_is_store = ex_mem_q.is_store;
  assign EX_MEM_is_sys   = ex_mem_q.is_sys;

endmodule

// File: tb/tb_execute_stage.sv
// Directed testbench for execute_stage with hand-computed expected values.
module tb_execute_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        HREADY_D;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_pc, ID_EX_inst, ID_EX_rs1, ID_EX_rs2, ID_EX_imm, ID_EX_csr_rdata;
  logic [4:0]  ID_EX_rd;
  logic [31:0] EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2, EX_MEM_csr_data;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_is_load, EX_MEM_is_store, EX_MEM_is_sys;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ex_stall;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 CLK = ~CLK;

  execute_stage dut (
    .CLK             (CLK),
    .RST             (RST),
    .HREADY_D        (HREADY_D),
    .ID_EX_valid     (ID_EX_valid),
    .ID_EX_pc        (ID_EX_pc),
    .ID_EX_inst      (ID_EX_inst),
    .ID_EX_rs1       (ID_EX_rs1),
    .ID_EX_rs2       (ID_EX_rs2),
    .ID_EX_imm       (ID_EX_imm),
    .ID_EX_rd        (ID_EX_rd),
    .ID_EX_csr_rdata (ID_EX_csr_rdata),
    .EX_MEM_pc       (EX_MEM_pc),
    .EX_MEM_inst     (EX_MEM_inst),
    .EX_MEM_alu      (EX_MEM_alu),
    .EX_MEM_rs2      (EX_MEM_rs2),
    .EX_MEM_csr_data (EX_MEM_csr_data),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_is_load  (EX_MEM_is_load),
    .EX_MEM_is_store (EX_MEM_is_store),
    .EX_MEM_is_sys   (EX_MEM_is_sys),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .ex_stall        (ex_stall)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic present(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd,
                         input logic [31:0] csr);
    ID_EX_valid = v; ID_EX_pc = pc; ID_EX_inst = inst; ID_EX_rs1 = rs1;
    ID_EX_rs2 = rs2; ID_EX_imm = imm; ID_EX_rd = rd; ID_EX_csr_rdata = csr;
    #1;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic ld, input logic st, input logic sy);
    check({tag, ".is_load"},  EX_MEM_is_load,  ld);
    check({tag, ".is_store"}, EX_MEM_is_store, st);
    check({tag, ".is_sys"},   EX_MEM_is_sys,   sy);
  endtask

  initial begin
    RST = 1'b1;
    HREADY_D = 1'b1;
    // JAL presented during reset: redirect must stay low
    present(1'b1, 32'h200, 32'h040000EF, 32'h0, 32'h0, 32'h40, 5'd1, 32'h0);
    #1;
    check("rst.inst", EX_MEM_inst, 32'h00000013);
    check("rst.pc", EX_MEM_pc, 32'h0);
    check("rst.rd", EX_MEM_rd, 32'h0);
    check("rst.alu", EX_MEM_alu, 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst.branch_taken", branch_taken, 1'b0);
    tick; tick;
    RST = 1'b0;

    // ADDI x3, -7 (inst[30]=1 is immediate, not SUB)
    present(1'b1, 32'h10, 32'hFF900193, 32'd5, 32'h55, 32'hFFFFFFF9, 5'd3, 32'h77);
    check("addi.branch_taken", branch_taken, 1'b0);
    tick;
    check("addi.alu", EX_MEM_alu, 32'hFFFFFFFE);
    check("addi.rd", EX_MEM_rd, 32'd3);
    check("addi.pc", EX_MEM_pc, 32'h10);
    check("addi.csr", EX_MEM_csr_data, 32'h0);
    check_flags("addi", 1'b0, 1'b0, 1'b0);

    // SB
    present(1'b1, 32'h14, 32'h00A081A3, 32'h1000, 32'h000000A5, 32'd3, 5'd3, 32'h0);
    tick;
    check("sb.alu", EX_MEM_alu, 32'h1003);
    check("sb.rs2", EX_MEM_rs2, 32'hA5A5A5A5);
    check("sb.rd", EX_MEM_rd, 32'd0);
    check_flags("sb", 1'b0, 1'b1, 1'b0);

    // SH
    present(1'b1, 32'h18, 32'h00A091A3, 32'h2000, 32'h1234BEEF, 32'd2, 5'd3, 32'h0);
    tick;
    check("sh.rs2", EX_MEM_rs2, 32'hBEEFBEEF);

    // BLT -1 < 1 signed -> taken
    present(1'b1, 32'h100, 32'h00004063, 32'hFFFFFFFF, 32'd1, 32'd16, 5'd8, 32'h0);
    check("blt.branch_taken", branch_taken, 1'b1);
    check("blt.branch_target", branch_target, 32'h110);
    tick;
    check("blt.alu", EX_MEM_alu, 32'h0);
    check("blt.rd", EX_MEM_rd, 32'd0);
    check("blt.inst", EX_MEM_inst, 32'h00004063);

    // BLTU 0xFFFFFFFF < 1 unsigned -> not taken
    present(1'b1, 32'h100, 32'h00006063, 32'hFFFFFFFF, 32'd1, 32'd16, 5'd0, 32'h0);
    check("bltu.branch_taken", branch_taken, 1'b0);
    tick;
    // BGEU -> taken
    present(1'b1, 32'h104, 32'h00007063, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF0, 5'd0, 32'h0);
    check("bgeu.branch_taken", branch_taken, 1'b1);
    check("bgeu.branch_target", branch_target, 32'h000000F4);
    tick;

    // JALR
    present(1'b1, 32'h40, 32'h00008067, 32'h2001, 32'h0, 32'd2, 5'd1, 32'h0);
    check("jalr.branch_taken", branch_taken, 1'b1);
    check("jalr.branch_target", branch_target, 32'h2002);
    tick;
    check("jalr.alu", EX_MEM_alu, 32'h44);
    check("jalr.rd", EX_MEM_rd, 32'd1);

    // LUI, AUIPC
    present(1'b1, 32'h44, 32'h123450B7, 32'hDEAD, 32'h0, 32'h12345000, 5'd1, 32'h0);
    tick;
    check("lui.alu", EX_MEM_alu, 32'h12345000);
    present(1'b1, 32'h1000, 32'h00001117, 32'hDEAD, 32'h0, 32'h1000, 5'd2, 32'h0);
    tick;
    check("auipc.alu", EX_MEM_alu, 32'h2000);

    // SUB, SRAI, SLT, SLTU
    present(1'b1, 32'h48, 32'h40208033, 32'd10, 32'd3, 32'h400, 5'd0, 32'h0);
    tick;
    check("sub.alu", EX_MEM_alu, 32'd7);
    present(1'b1, 32'h4C, 32'h40405093, 32'h80000000, 32'h0, 32'h404, 5'd1, 32'h0);
    tick;
    check("srai.alu", EX_MEM_alu, 32'hF8000000);
    present(1'b1, 32'h50, 32'h002020B3, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd1, 32'h0);
    tick;
    check("slt.alu", EX_MEM_alu, 32'd1);
    present(1'b1, 32'h54, 32'h002030B3, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd1, 32'h0);
    tick;
    check("sltu.alu", EX_MEM_alu, 32'd0);

    // SYS passes csr value
    present(1'b1, 32'h60, 32'h30002173, 32'h5, 32'h0, 32'h300, 5'd2, 32'hCAFE0001);
    tick;
    check("sys.csr", EX_MEM_csr_data, 32'hCAFE0001);
    check("sys.alu", EX_MEM_alu, 32'h0);
    check("sys.rd", EX_MEM_rd, 32'd2);
    check_flags("sys", 1'b0, 1'b0, 1'b1);

    // bubbles: invalid, then unknown opcode
    present(1'b0, 32'h999, 32'h00002003, 32'h1, 32'h2, 32'h3, 5'd4, 32'h5);
    tick;
    check("bub.inst", EX_MEM_inst, 32'h00000013);
    check("bub.pc", EX_MEM_pc, 32'h60);
    check("bub.rd", EX_MEM_rd, 32'd0);
    check_flags("bub", 1'b0, 1'b0, 1'b0);
    present(1'b1, 32'h70, 32'h0000007F, 32'h1, 32'h2, 32'h3, 5'd4, 32'h5);
    check("unk.branch_taken", branch_taken, 1'b0);
    tick;
    check("unk.inst", EX_MEM_inst, 32'h00000013);
    check("unk.pc", EX_MEM_pc, 32'h60);

    // stall: LW accepted, then JAL held for 3 stalled cycles
    present(1'b1, 32'h80, 32'h0084A383, 32'h100, 32'h0, 32'd8, 5'd7, 32'h0);
    tick;
    check("lw.alu", EX_MEM_alu, 32'h108);
    check("lw.rd", EX_MEM_rd, 32'd7);
    check_flags("lw", 1'b1, 1'b0, 1'b0);
    HREADY_D = 1'b0;
    present(1'b1, 32'h200, 32'h040000EF, 32'h0, 32'h0, 32'h40, 5'd1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("stall.branch_taken", branch_taken, 1'b0);
      check("stall.ex_stall", ex_stall, 1'b1);
      tick;
      check("stall.alu", EX_MEM_alu, 32'h108);
      check("stall.inst", EX_MEM_inst, 32'h0084A383);
      check("stall.is_load", EX_MEM_is_load, 1'b1);
      $display("stall cycle %0d: alu=%h taken=%b", i, EX_MEM_alu, branch_taken);
    end
    HREADY_D = 1'b1;
    #1;
    check("jal.branch_taken", branch_taken, 1'b1);
    check("jal.branch_target", branch_target, 32'h240);
    check("jal.ex_stall", ex_stall, 1'b0);
    tick;
    check("jal.alu", EX_MEM_alu, 32'h204);
    check("jal.inst", EX_MEM_inst, 32'h040000EF);
    check("jal.pc", EX_MEM_pc, 32'h200);
    check("jal.is_load", EX_MEM_is_load, 1'b0);

    // reset in the middle of a stall
    present(1'b1, 32'h84, 32'h0084A383, 32'h100, 32'h0, 32'd8, 5'd7, 32'h0);
    tick;
    check("lw2.is_load", EX_MEM_is_load, 1'b1);
    HREADY_D = 1'b0;
    present(1'b1, 32'h88, 32'h0020A223, 32'h300, 32'h11223344, 32'd4, 5'd4, 32'h0);
    #1;
    RST = 1'b1;
    #1;
    check("rstmid.inst", EX_MEM_inst, 32'h00000013);
    check("rstmid.pc", EX_MEM_pc, 32'h0);
    check("rstmid.alu", EX_MEM_alu, 32'h0);
    check_flags("rstmid", 1'b0, 1'b0, 1'b0);
    tick;
    RST = 1'b0;
    tick; tick;
    check("post.inst", EX_MEM_inst, 32'h00000013);
    check("post.is_load", EX_MEM_is_load, 1'b0);
    check("post.is_store", EX_MEM_is_store, 1'b0);
    HREADY_D = 1'b1;
    tick;
    check("sw.is_store", EX_MEM_is_store, 1'b1);
    check("sw.alu", EX_MEM_alu, 32'h304);
    check("sw.rs2", EX_MEM_rs2, 32'h11223344);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have port CLK, input, 1, rising-edge clock.
REQ-002 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-003 SHALL have port HREADY_D, input, 1, data-bus ready; low means the memory stage is stalled.
REQ-004 SHALL have port ID_EX_valid, input, 1, high when ID_EX holds a real instruction.
REQ-005 SHALL have ports ID_EX_pc and ID_EX_inst, input, 32 each, instruction address and word.
REQ-006 SHALL have ports ID_EX_rs1 and ID_EX_rs2, input, 32 each, already-forwarded operands.
REQ-007 SHALL have port ID_EX_imm, input, 32, sign-extended immediate for the instruction format.
REQ-008 SHALL have port ID_EX_rd, input, 5, destination register.
REQ-009 SHALL have port ID_EX_csr_rdata, input, 32, current CSR value for SYS instructions.
REQ-010 SHALL have registered outputs EX_MEM_pc, EX_MEM_inst, EX_MEM_alu, EX_MEM_rs2, EX_MEM_csr_data (32 each), EX_MEM_rd (5), and EX_MEM_is_load, EX_MEM_is_store, EX_MEM_is_sys (1 each).
REQ-011 SHALL have output branch_taken, 1, combinational redirect request.
REQ-012 SHALL have output branch_target, 32, combinational redirect address.
REQ-013 SHALL have output ex_stall, 1, equal to ~HREADY_D, telling upstream to hold ID_EX.

Function
REQ-014 SHALL decode opcode ID_EX_inst[6:0] as LUI, AUIPC, JAL, JALR, BCC, LCC, SCC, MCC, RCC or SYS; any other opcode is treated as a bubble.
REQ-015 SHALL compute the ALU result per opcode:
- LUI: imm.
- AUIPC: pc+imm.
- JAL/JALR: pc+4.
- LCC/SCC: rs1+imm.
- MCC/RCC: the RV32I op selected by funct3/funct7[5]; shift amount is operand[4:0]; SLT/SLTI are signed; SLTU/SLTIU are unsigned; SUB and SRA are used only for RCC or SRAI.
- BCC: 0.
- SYS: 0.
REQ-016 SHALL store write data on EX_MEM_rs2 lane-replicated: SB gives {4{rs2[7:0]}}, SH gives {2{rs2[15:0]}}, SW gives rs2.
REQ-017 SHALL evaluate branches with BEQ/BNE/BLT/BGE (signed) and BLTU/BGEU (unsigned) on rs1/rs2; the target is pc+imm.
REQ-018 SHALL set the JALR target to (rs1+imm) with bit0 cleared, and the JAL target to pc+imm.
REQ-019 SHALL assert branch_taken only when ID_EX_valid is high, HREADY_D is high, and the instruction is JAL, JALR or a satisfied BCC; otherwise branch_taken is 0 and branch_target is don't-care.
REQ-020 SHALL update all EX_MEM registers on a rising CLK edge only when HREADY_D is high; when HREADY_D is low they hold and branch_taken is suppressed.
REQ-021 SHALL, when HREADY_D is high and the instruction is a bubble (ID_EX_valid low or unknown opcode), load a bubble into EX_MEM: inst=32'h00000013, rd=0, alu=0, rs2=0, csr_data=0, all is_* flags 0, pc held.
REQ-022 SHALL set EX_MEM_is_load for LCC, EX_MEM_is_store for SCC and EX_MEM_is_sys for SYS, and pass ID_EX_csr_rdata to EX_MEM_csr_data for SYS only (0 otherwise).
REQ-023 SHALL force EX_MEM_rd to 0 for BCC and SCC.
REQ-024 SHALL have one-cycle latency from an ID_EX instruction to its EX_MEM image when not stalled.
REQ-025 SHALL register a taken branch itself normally; flushing the younger instruction in ID_EX is the upstream stage's job in response to branch_taken.
REQ-026 SHALL, for a valid instruction arriving with HREADY_D low, process it exactly once, on the first edge at which HREADY_D is high.

Reset
REQ-027 SHALL, while RST is high, asynchronously force EX_MEM to the bubble of REQ-021 with EX_MEM_pc=0; branch_taken is 0 during reset.
REQ-028 SHALL, if RST asserts mid-stall, discard the held contents; after release, EX_MEM_is_load=EX_MEM_is_store=0 until a valid memory instruction is accepted.

Structure
REQ-029 SHALL place the opcode constants (LUI..SYS), the NOP encoding and the funct3 codes in a shared package used by the decode, execute and memory stages.
REQ-030 SHALL implement the purely combinational ALU in one sub-module named alu (inputs a, b, funct3, alt bit; output 32-bit result); branch compare and target logic stay in execute_stage.

Verification
REQ-031 SHALL cover ADDI: rs1=5, imm=-7, HREADY_D=1 -> next cycle EX_MEM_alu=32'hFFFFFFFE, rd unchanged, flags 0.
REQ-032 SHALL cover SB: rs1=32'h1000, imm=3, rs2=32'h000000A5 -> EX_MEM_alu=32'h1003, EX_MEM_rs2=32'hA5A5A5A5, is_store=1, rd=0.
REQ-033 SHALL cover BLT with rs1=32'hFFFFFFFF, rs2=1 at pc=32'h100, imm=16 -> branch_taken=1, branch_target=32'h110; BLTU with the same operands -> branch_taken=0.
REQ-034 SHALL cover JALR: rs1=32'h2001, imm=2 at pc=32'h40 -> branch_target=32'h2002, EX_MEM_alu=32'h44.
REQ-035 SHALL cover a stall: LW accepted, then HREADY_D low for 3 cycles with a new instruction presented -> EX_MEM unchanged and branch_taken=0 for all 3 cycles; the new instruction is captured on the first HREADY_D-high edge.
REQ-036 SHALL cover reset mid-stall: RST pulse while HREADY_D=0 -> immediate EX_MEM_inst=32'h00000013, all flags 0, EX_MEM_pc=0.
